// File: rtl/tape_fsk_player.sv
// tape_fsk_player: cassette playback for the MC-10.
// Reads .c10 image bytes through the SDRAM byte port and plays them on the cin
// input as FSK, LSB first. A '1' bit is one 2400 Hz cycle and a '0' bit is one 1200 Hz cycle.
// Optional feature: define TAPE_MOTOR_EN to add the cassette motor relay input.
// Memory handshake: mem_rd is a one-cycle strobe carrying mem_addr. mem_data is taken
// exactly RD_LATENCY cycles later. There is no back-pressure and no ready signal.
module tape_fsk_player #(
    parameter int HALF1_CYC  = 833,
    parameter int HALF0_CYC  = 1667,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        rewind,
`ifdef TAPE_MOTOR_EN
    input  logic        motor,
`endif
    input  logic [24:0] file_len,
    output logic [24:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic        data,
    output logic        playing,
    output logic        at_end,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2,
        S_END   = 2'd3
    } state_t;

    localparam int HMAX = (HALF0_CYC > HALF1_CYC) ? HALF0_CYC : HALF1_CYC;
    localparam int HCW  = $clog2(HMAX + 1);
    localparam int FCW  = $clog2(RD_LATENCY + 2);
    // The read is strobed in FETCH count 0 and seen by memory in count 1.
    // Data is therefore valid in count RD_LATENCY+1.
    localparam logic [FCW-1:0] FETCH_LAST = FCW'(RD_LATENCY + 1);

    state_t          state_q, state_d;
    logic            play_r1_q, play_r1_d, play_r2_q, play_r2_d;
    logic            rew_r1_q, rew_r1_d, rew_r2_q, rew_r2_d;
    logic [24:0]     flen_q, flen_d;
    logic [24:0]     addr_q, addr_d;
    logic            rd_q, rd_d;
    logic            data_q, data_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [HCW-1:0]  hcnt_q, hcnt_d;
    logic            phase_q, phase_d;      // 0 = high half, 1 = low half
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic            pause_q, pause_d;
    logic            playing_q, playing_d;
    logic            at_end_q, at_end_d;

    logic            play_edge, rew_edge, frozen;
    logic [HCW-1:0]  half_m1;

    assign play_edge = play_r1_q & ~play_r2_q;
    assign rew_edge  = rew_r1_q & ~rew_r2_q;
    assign half_m1   = shift_q[0] ? HCW'(HALF1_CYC - 1) : HCW'(HALF0_CYC - 1);

    // When the motor is off, playback stops. A read that has already been issued
    // is allowed to finish so that its data is not lost.
`ifdef TAPE_MOTOR_EN
    assign frozen = ~motor & ((state_q == S_PLAY) ||
                              ((state_q == S_FETCH) && (fcnt_q == '0)));
`else
    assign frozen = 1'b0;
`endif

    // Next-state logic: edge detect, fetch sequencing and bit/half-period timing.
    always_comb begin
        state_d   = state_q;
        play_r1_d = play;
        play_r2_d = play_r1_q;
        rew_r1_d  = rewind;
        rew_r2_d  = rew_r1_q;
        flen_d    = flen_q;
        addr_d    = addr_q;
        rd_d      = 1'b0;
        data_d    = data_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        hcnt_d    = hcnt_q;
        phase_d   = phase_q;
        fcnt_d    = fcnt_q;
        pause_d   = pause_q;

        if (rew_edge) begin
            // Rewind takes priority over everything, including a play edge in the same cycle.
            state_d   = S_IDLE;
            flen_d    = file_len;
            addr_d    = '0;
            data_d    = 1'b0;
            bit_idx_d = '0;
            hcnt_d    = '0;
            phase_d   = 1'b0;
            fcnt_d    = '0;
            pause_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (play_edge) begin
                        flen_d = file_len;
                        fcnt_d = '0;
                        if ((file_len != '0) && (addr_q < file_len)) state_d = S_FETCH;
                        else                                         state_d = S_END;
                    end
                end
                S_FETCH: begin
                    if (play_edge) pause_d = ~pause_q;
                    if (!frozen) begin
                        if (fcnt_q == '0) rd_d = 1'b1;
                        if (fcnt_q == FETCH_LAST) begin
                            shift_d   = mem_data;
                            addr_d    = addr_q + 25'd1;
                            bit_idx_d = '0;
                            hcnt_d    = '0;
                            phase_d   = 1'b0;
                            data_d    = 1'b1;
                            fcnt_d    = '0;
                            state_d   = S_PLAY;
                        end else begin
                            fcnt_d = fcnt_q + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (play_edge) pause_d = ~pause_q;
                    if (!frozen) begin
                        if (hcnt_q != half_m1) begin
                            hcnt_d = hcnt_q + 1'b1;
                        end else begin
                            hcnt_d = '0;
                            if (!phase_q) begin
                                phase_d = 1'b1;
                                data_d  = 1'b0;
                            end else begin
                                phase_d = 1'b0;
                                if (bit_idx_q != 3'd7) begin
                                    shift_d   = {1'b0, shift_q[7:1]};
                                    bit_idx_d = bit_idx_q + 3'd1;
                                    data_d    = 1'b1;
                                end else begin
                                    // This is a byte boundary: the file ends, a pause applies, or the next byte is fetched.
                                    data_d    = 1'b0;
                                    bit_idx_d = '0;
                                    if (addr_q >= flen_q) begin
                                        state_d = S_END;
                                        pause_d = 1'b0;
                                    end else if (pause_q) begin
                                        state_d = S_IDLE;
                                        pause_d = 1'b0;
                                    end else begin
                                        state_d = S_FETCH;
                                        fcnt_d  = '0;
                                    end
                                end
                            end
                        end
                    end
                end
                default: begin
                    data_d = 1'b0;
                end
            endcase
        end

        playing_d = (state_d == S_FETCH) || (state_d == S_PLAY);
        at_end_d  = (state_d == S_END);
    end

    // State and datapath registers. Reset is synchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            play_r1_q <= 1'b0;
            play_r2_q <= 1'b0;
            rew_r1_q  <= 1'b0;
            rew_r2_q  <= 1'b0;
            flen_q    <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            data_q    <= 1'b0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            hcnt_q    <= '0;
            phase_q   <= 1'b0;
            fcnt_q    <= '0;
            pause_q   <= 1'b0;
            playing_q <= 1'b0;
            at_end_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            play_r1_q <= play_r1_d;
            play_r2_q <= play_r2_d;
            rew_r1_q  <= rew_r1_d;
            rew_r2_q  <= rew_r2_d;
            flen_q    <= flen_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            hcnt_q    <= hcnt_d;
            phase_q   <= phase_d;
            fcnt_q    <= fcnt_d;
            pause_q   <= pause_d;
            playing_q <= playing_d;
            at_end_q  <= at_end_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_rd    = rd_q;
    assign data      = data_q;
    assign playing   = playing_q;
    assign at_end    = at_end_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tape_fsk_player.sv
// tb_tape_fsk_player: bench for tape_fsk_player.
// One instance uses the real tape timing. A second instance uses short half-periods
// so that the randomized multi-byte runs stay short.
`timescale 1ns/1ps
module tb_tape_fsk_player;

    localparam int S_H1 = 5, S_H0 = 9, S_LAT = 3;
    localparam int F_H1 = 833, F_H0 = 1667, F_LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, play, rewind, motor, use_full;
    logic [24:0] file_len;
    logic [7:0]  mem_data;
    logic        rst_s, rst_f;
    assign rst_s = reset | use_full;
    assign rst_f = reset | ~use_full;

    logic [24:0] addr_s, addr_f;
    logic        rd_s, rd_f, data_s, data_f, pl_s, pl_f, end_s, end_f;
    logic [1:0]  st_s, st_f;

    tape_fsk_player #(.HALF1_CYC(S_H1), .HALF0_CYC(S_H0), .RD_LATENCY(S_LAT)) dut (
        .clk(clk), .reset(rst_s), .play(play), .rewind(rewind),
`ifdef TAPE_MOTOR_EN
        .motor(motor),
`endif
        .file_len(file_len), .mem_addr(addr_s), .mem_rd(rd_s), .mem_data(mem_data),
        .data(data_s), .playing(pl_s), .at_end(end_s), .dbg_state(st_s)
    );

    tape_fsk_player dut_full (
        .clk(clk), .reset(rst_f), .play(play), .rewind(rewind),
`ifdef TAPE_MOTOR_EN
        .motor(motor),
`endif
        .file_len(file_len), .mem_addr(addr_f), .mem_rd(rd_f), .mem_data(mem_data),
        .data(data_f), .playing(pl_f), .at_end(end_f), .dbg_state(st_f)
    );

    logic [24:0] o_addr;
    logic        o_rd, o_data, o_pl, o_end;
    logic [1:0]  o_st;
    always_comb begin
        o_addr = use_full ? addr_f : addr_s;
        o_rd   = use_full ? rd_f   : rd_s;
        o_data = use_full ? data_f : data_s;
        o_pl   = use_full ? pl_f   : pl_s;
        o_end  = use_full ? end_f  : end_s;
        o_st   = use_full ? st_f   : st_s;
    end

    // ---------------- memory model with fixed read latency ----------------
    logic [7:0]  mem [0:15];
    bit          pv [0:8];
    logic [24:0] pa [0:8];
    int          lat;
    always @(negedge clk) begin
        lat = use_full ? F_LAT : S_LAT;
        for (int i = 8; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = o_rd;
        pa[0] = o_addr;
        if (pv[lat]) mem_data = mem[pa[lat][3:0]];
        else         mem_data = 8'($urandom);
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0, n_err = 0;
    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected waveform is a list of runs: +n means n cycles high, -n means n cycles low.
    int exp_runs[$];
    int obs_runs[$];
    int obs_rd[$];
    int stop_idx;
    logic stop_data;

    task automatic push_run(input int v);
        if (exp_runs.size() > 0 && ((exp_runs[exp_runs.size()-1] > 0) == (v > 0)))
            exp_runs[exp_runs.size()-1] += v;
        else
            exp_runs.push_back(v);
    endtask

    // Expected waveform after a play edge for bytes first..last. It starts with
    // 1 cycle of edge registration, 1 cycle of action and RD_LATENCY+2 cycles of fetch,
    // then the FSK bits. Consecutive bytes are separated by RD_LATENCY+2 cycles low.
    task automatic build_exp(input int first, input int last, input int h1, input int h0, input int l);
        logic [7:0] b;
        int h;
        exp_runs.delete();
        push_run(-(l + 3));
        for (int k = first; k <= last; k++) begin
            b = mem[k];
            for (int i = 0; i < 8; i++) begin
                h = b[i] ? h1 : h0;
                push_run(h);
                push_run(-h);
            end
            if (k != last) push_run(-(l + 2));
        end
    endtask

    function automatic int bit_start(input logic [7:0] b, input int n, input int h1, input int h0, input int l);
        int t;
        t = l + 3;
        for (int i = 0; i < n; i++) t += 2 * (b[i] ? h1 : h0);
        return t;
    endfunction

    // ---------------- driver / monitor ----------------
    // The caller raises play just before this task is called. Samples are taken on falling edges.
    task automatic record(input int max_cyc, input int p1, input int p2, input int rw_at,
                          input int mo_at, input int mo_len, output bit timed_out);
        int cur, v;
        bit started;
        obs_runs.delete();
        obs_rd.delete();
        cur = 0;
        started = 0;
        timed_out = 1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (started && (o_end || !o_pl)) begin
                stop_idx  = i;
                stop_data = o_data;
                timed_out = 0;
                break;
            end
            if (o_pl) started = 1;
            if (o_rd) obs_rd.push_back(int'(o_addr));
            v = o_data ? 1 : -1;
            if (cur == 0) cur = v;
            else if ((cur > 0) == (v > 0)) cur += v;
            else begin
                obs_runs.push_back(cur);
                cur = v;
            end
            play   = (i == p1) || (i == p2);
            rewind = (i == rw_at);
            motor  = !((i >= mo_at) && (i < mo_at + mo_len));
        end
        if (cur != 0) obs_runs.push_back(cur);
        play = 0;
        rewind = 0;
        motor = 1;
    endtask

    task automatic cmp_runs(input string tag, input bit timed_out);
        check_eq({tag, "_timeout"}, timed_out, 0);
        check_eq({tag, "_nruns"}, obs_runs.size(), exp_runs.size());
        for (int j = 0; j < obs_runs.size() && j < exp_runs.size(); j++)
            check_eq({tag, "_run"}, obs_runs[j], exp_runs[j]);
    endtask

    task automatic cmp_rd(input string tag, input int first, input int last);
        check_eq({tag, "_nrd"}, obs_rd.size(), last - first + 1);
        for (int j = 0; j < obs_rd.size() && j <= last - first; j++)
            check_eq({tag, "_rdaddr"}, obs_rd[j], first + j);
    endtask

    task automatic idle_cycles(input int n, output int rds);
        rds = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_rd) rds++;
        end
    endtask

    task automatic pulse_rewind();
        @(negedge clk) rewind = 1;
        @(negedge clk) rewind = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_play();
        @(negedge clk) play = 1;
        @(negedge clk) play = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit to;
        int rds, idx, flen;
        reset = 1; play = 0; rewind = 0; motor = 1; use_full = 1; file_len = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_eq("rst_data", o_data, 0);
        check_eq("rst_addr", o_addr, 0);
        check_eq("rst_rd", o_rd, 0);
        check_eq("rst_playing", o_pl, 0);
        check_eq("rst_at_end", o_end, 0);
        reset = 0;
        @(negedge clk);

        // Real timing: a single byte 0x01 gives 833/833 and then 7 x 1667/1667.
        mem[0] = 8'h01; file_len = 25'd1;
        build_exp(0, 0, F_H1, F_H0, F_LAT);
        @(negedge clk) play = 1;
        record(30000, -1, -1, -1, -1, 0, to);
        cmp_runs("full_one", to);
        cmp_rd("full_one", 0, 0);
        check_eq("full_one_at_end", o_end, 1);
        check_eq("full_one_addr", o_addr, 1);
        check_eq("full_one_data", stop_data, 0);

        // The remaining tests use the short-timing instance.
        use_full = 0;
        repeat (3) @(negedge clk);

        // Two bytes, 0xFF then 0x00.
        mem[0] = 8'hFF; mem[1] = 8'h00; file_len = 25'd2;
        build_exp(0, 1, S_H1, S_H0, S_LAT);
        @(negedge clk) play = 1;
        record(3000, -1, -1, -1, -1, 0, to);
        cmp_runs("two", to);
        cmp_rd("two", 0, 1);
        check_eq("two_addr", o_addr, 2);
        check_eq("two_at_end", o_end, 1);

        // An empty file goes straight to END, and play edges in END are ignored.
        file_len = '0;
        pulse_rewind();
        check_eq("empty_rew_end", o_end, 0);
        pulse_play();
        idle_cycles(6, rds);
        check_eq("empty_at_end", o_end, 1);
        check_eq("empty_rd", rds, 0);
        pulse_play();
        idle_cycles(6, rds);
        check_eq("empty_end_hold", o_end, 1);
        check_eq("empty_playing", o_pl, 0);
        check_eq("empty_rd2", rds, 0);

        // When rewind and play arrive in the same cycle, rewind wins.
        file_len = 25'd2;
        pulse_rewind();
        @(negedge clk) begin rewind = 1; play = 1; end
        @(negedge clk) begin rewind = 0; play = 0; end
        idle_cycles(6, rds);
        check_eq("rewplay_state", o_st, 0);
        check_eq("rewplay_rd", rds, 0);

        // Rewind in the middle of a high half, then replay from byte 0.
        mem[0] = 8'h02; mem[1] = 8'($urandom);
        idx = S_LAT + 5;
        @(negedge clk) play = 1;
        record(500, -1, -1, idx, -1, 0, to);
        check_eq("rew_timeout", to, 0);
        check_eq("rew_latency", stop_idx, idx + 2);
        check_eq("rew_data", stop_data, 0);
        check_eq("rew_addr", o_addr, 0);
        check_eq("rew_state", o_st, 0);
        build_exp(0, 1, S_H1, S_H0, S_LAT);
        @(negedge clk) play = 1;
        record(3000, -1, -1, -1, -1, 0, to);
        cmp_runs("rew_replay", to);
        cmp_rd("rew_replay", 0, 1);

        // A play edge during bit 3 of byte 0 pauses playback at the byte boundary.
        file_len = 25'd3;
        for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
        pulse_rewind();
        idx = bit_start(mem[0], 3, S_H1, S_H0, S_LAT) + 2;
        build_exp(0, 0, S_H1, S_H0, S_LAT);
        @(negedge clk) play = 1;
        record(3000, idx, -1, -1, -1, 0, to);
        cmp_runs("pause", to);
        cmp_rd("pause", 0, 0);
        check_eq("pause_state", o_st, 0);
        check_eq("pause_addr", o_addr, 1);
        check_eq("pause_playing", o_pl, 0);
        build_exp(1, 2, S_H1, S_H0, S_LAT);
        @(negedge clk) play = 1;
        record(3000, -1, -1, -1, -1, 0, to);
        cmp_runs("resume", to);
        cmp_rd("resume", 1, 2);
        check_eq("resume_at_end", o_end, 1);

        // Randomized files. Some runs include a pause followed by a quick resume, which must leave no gap.
        for (int it = 0; it < 8; it++) begin
            flen = $urandom_range(1, 4);
            for (int i = 0; i < flen; i++) mem[i] = 8'($urandom);
            file_len = 25'(flen);
            pulse_rewind();
            idx = -1;
            if ($urandom_range(0, 1) == 1)
                idx = bit_start(mem[0], $urandom_range(1, 5), S_H1, S_H0, S_LAT) + 1;
            build_exp(0, flen - 1, S_H1, S_H0, S_LAT);
            @(negedge clk) play = 1;
            record(4000, idx, (idx < 0) ? -1 : idx + 2, -1, -1, 0, to);
            cmp_runs("rand", to);
            cmp_rd("rand", 0, flen - 1);
            check_eq("rand_addr", o_addr, flen);
            check_eq("rand_at_end", o_end, 1);
        end

`ifdef TAPE_MOTOR_EN
        // Holding the motor off for 1000 cycles during the first high half stretches that half by exactly 1000 cycles.
        file_len = 25'd1;
        mem[0] = 8'($urandom);
        pulse_rewind();
        build_exp(0, 0, S_H1, S_H0, S_LAT);
        exp_runs[1] += 1000;
        @(negedge clk) play = 1;
        record(4000, -1, -1, -1, S_LAT + 4, 1000, to);
        cmp_runs("motor", to);
        cmp_rd("motor", 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound in case the sequence above stops making progress.
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
